// File: rtl/uart_tx_pkg.sv
// Shared constants for the UART transmit path: FSM state encoding and line levels.
package uart_tx_pkg;

  localparam int TX_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic PAR_EVEN   = 1'b0;
  localparam logic PAR_ODD    = 1'b1;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Computes the frame parity bit from the incoming byte and holds it for the whole frame.
module uart_tx_parity_calc
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = TX_DATA_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  PAR_TYP,
  input  logic                  load,
  output logic                  parity_bit
);

  logic parity_nx;

  always_comb begin
    parity_nx = ^data;
    if (PAR_TYP == PAR_ODD) begin
      parity_nx = ~(^data);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      parity_bit <= 1'b0;
    end else if (load) begin
      parity_bit <= parity_nx;
    end
  end

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmit frame controller: latches a byte, drives the serializer and muxes
// start/data/parity/stop onto TX_OUT. Handshake: a request is taken on any CLK edge
// where DATA_VALID=1 and the FSM is in IDLE or STOP; in any other state it is ignored.
module uart_tx_fsm
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = TX_DATA_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_data,
  input  logic                  ser_done,
  output logic                  ser_en,
  output logic [DATA_WIDTH-1:0] ser_p_data,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic [2:0]            state_dbg
);

  tx_state_e             state, state_nx;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  par_en_reg;
  logic                  parity_bit;
  logic                  accept;

  assign accept = DATA_VALID && ((state == ST_IDLE) || (state == ST_STOP));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data_reg   <= '0;
      par_en_reg <= 1'b0;
    end else if (accept) begin
      data_reg   <= P_DATA;
      par_en_reg <= PAR_EN;
    end
  end

  uart_tx_parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .CLK        (CLK),
    .RST        (RST),
    .data       (P_DATA),
    .PAR_TYP    (PAR_TYP),
    .load       (accept),
    .parity_bit (parity_bit)
  );

  // ser_en drops on the bit-7 cycle so the serializer counter does not wrap into a new byte.
  always_comb begin
    state_nx = state;
    ser_en   = 1'b0;
    TX_OUT   = IDLE_LEVEL;
    busy     = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (DATA_VALID) state_nx = ST_START;
      end
      ST_START: begin
        TX_OUT   = START_BIT;
        ser_en   = 1'b1;
        state_nx = ST_DATA;
      end
      ST_DATA: begin
        TX_OUT = ser_data;
        ser_en = ~ser_done;
        if (ser_done) state_nx = par_en_reg ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        TX_OUT   = parity_bit;
        state_nx = ST_STOP;
      end
      ST_STOP: begin
        TX_OUT   = STOP_BIT;
        state_nx = DATA_VALID ? ST_START : ST_IDLE;
      end
      default: begin
        busy     = 1'b0;
        state_nx = ST_IDLE;
      end
    endcase
  end

  assign ser_p_data = data_reg;
  assign state_dbg  = state;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Bench for uart_tx_fsm: behavioural serializer plus a frame-level reference model.
module tb_uart_tx_fsm;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       ser_data;
  logic       ser_done;
  logic       ser_en;
  logic [7:0] ser_p_data;
  logic       TX_OUT;
  logic       busy;
  logic [2:0] state_dbg;

  int total = 0;
  int bad   = 0;

  uart_tx_fsm dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .ser_data   (ser_data),
    .ser_done   (ser_done),
    .ser_en     (ser_en),
    .ser_p_data (ser_p_data),
    .TX_OUT     (TX_OUT),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // serializer: starts on the first ser_en cycle, shifts bit k out on DATA cycle k+1
  logic       ser_active;
  logic [2:0] ser_cnt;
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ser_active <= 1'b0;
      ser_cnt    <= 3'd0;
    end else if (ser_en) begin
      if (!ser_active) begin
        ser_active <= 1'b1;
        ser_cnt    <= 3'd0;
      end else begin
        ser_cnt <= ser_cnt + 3'd1;
      end
    end else begin
      ser_active <= 1'b0;
    end
  end
  assign ser_data = ser_active ? ser_p_data[ser_cnt] : 1'b0;
  assign ser_done = ser_active && (ser_cnt == 3'd7);

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".tx"},     8'(TX_OUT), 8'h01);
    check({tag, ".busy"},   8'(busy),   8'h00);
    check({tag, ".ser_en"}, 8'(ser_en), 8'h00);
  endtask

  // driver: present a request and let one edge accept it, then scramble the inputs
  task automatic launch(input logic [7:0] d, input logic pe, input logic pt);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    DATA_VALID = 1'b1;
    @(posedge CLK);
    #1;
    DATA_VALID = 1'b0;
    P_DATA     = 8'($urandom);
    PAR_EN     = 1'($urandom_range(0, 1));
    PAR_TYP    = 1'($urandom_range(0, 1));
  endtask

  // scoreboard: walks one frame from its START cycle; optionally chains the next request in STOP
  task automatic check_frame(input logic [7:0] d, input logic pe, input logic pt,
                             input bit noise, input bit chain,
                             input logic [7:0] nd, input logic npe, input logic npt);
    logic [0:0] exp_q[$];
    logic [0:0] exp_bit;
    int         n;
    exp_q.push_back(1'b0);
    for (int b = 0; b < 8; b++) exp_q.push_back(d[b]);
    if (pe) exp_q.push_back(pt ? ~(^d) : (^d));
    exp_q.push_back(1'b1);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      exp_bit = exp_q.pop_front();
      check($sformatf("tx[%0d]", i),     8'(TX_OUT),     8'(exp_bit));
      check($sformatf("busy[%0d]", i),   8'(busy),       8'h01);
      check($sformatf("ser_en[%0d]", i), 8'(ser_en),     8'(i < 8));
      check($sformatf("pdata[%0d]", i),  ser_p_data,     d);
      if (i < n - 1) begin
        if (noise) begin
          DATA_VALID = 1'($urandom_range(0, 1));
          P_DATA     = 8'hFF;
          PAR_EN     = 1'($urandom_range(0, 1));
          PAR_TYP    = 1'($urandom_range(0, 1));
        end
      end else if (chain) begin
        P_DATA     = nd;
        PAR_EN     = npe;
        PAR_TYP    = npt;
        DATA_VALID = 1'b1;
      end else begin
        DATA_VALID = 1'b0;
      end
    end
    @(posedge CLK);
    #1;
    DATA_VALID = 1'b0;
    if (!chain) begin
      @(negedge CLK);
      check_idle("after_frame");
    end
  endtask

  logic [7:0] d, nd;
  logic       pe, pt, npe, npt;
  bit         chained, chain_n, noise;

  initial begin
    RST        = 1'b0;
    P_DATA     = 8'h00;
    DATA_VALID = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    repeat (3) @(negedge CLK);
    check_idle("reset");
    check("reset.pdata", ser_p_data, 8'h00);
    check("reset.state", 8'(state_dbg), 8'h00);
    RST = 1'b1;
    @(posedge CLK);
    #1;

    // directed frames
    launch(8'hA5, 1'b1, 1'b0); check_frame(8'hA5, 1'b1, 1'b0, 0, 0, 8'h00, 1'b0, 1'b0);
    launch(8'hA5, 1'b1, 1'b1); check_frame(8'hA5, 1'b1, 1'b1, 0, 0, 8'h00, 1'b0, 1'b0);
    launch(8'h00, 1'b1, 1'b1); check_frame(8'h00, 1'b1, 1'b1, 0, 0, 8'h00, 1'b0, 1'b0);
    launch(8'hFF, 1'b1, 1'b0); check_frame(8'hFF, 1'b1, 1'b0, 0, 0, 8'h00, 1'b0, 1'b0);
    launch(8'h3C, 1'b0, 1'b0); check_frame(8'h3C, 1'b0, 1'b0, 0, 0, 8'h00, 1'b0, 1'b0);

    // back-to-back: request held in STOP
    launch(8'hC3, 1'b1, 1'b1);
    check_frame(8'hC3, 1'b1, 1'b1, 0, 1, 8'h81, 1'b0, 1'b0);
    check_frame(8'h81, 1'b0, 1'b0, 0, 0, 8'h00, 1'b0, 1'b0);

    // requests during DATA/PARITY are ignored
    launch(8'h55, 1'b1, 1'b0); check_frame(8'h55, 1'b1, 1'b0, 1, 0, 8'h00, 1'b0, 1'b0);
    launch(8'h55, 1'b0, 1'b1); check_frame(8'h55, 1'b0, 1'b1, 1, 0, 8'h00, 1'b0, 1'b0);

    // asynchronous reset during data bit 4
    launch(8'h6B, 1'b1, 1'b0);
    repeat (6) @(negedge CLK);
    check("pre_rst.tx", 8'(TX_OUT), 8'(8'h6B >> 4) & 8'h01);
    #2;
    RST = 1'b0;
    #1;
    check_idle("mid_rst");
    check("mid_rst.pdata", ser_p_data, 8'h00);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    launch(8'h12, 1'b1, 1'b1); check_frame(8'h12, 1'b1, 1'b1, 0, 0, 8'h00, 1'b0, 1'b0);

    // randomized frames, some chained, some with ignored request noise
    chained = 0;
    d  = 8'($urandom);
    pe = 1'($urandom_range(0, 1));
    pt = 1'($urandom_range(0, 1));
    for (int k = 0; k < 16; k++) begin
      if (!chained) launch(d, pe, pt);
      chain_n = (k < 15) && ($urandom_range(0, 2) == 0);
      noise   = 1'($urandom_range(0, 1));
      nd  = 8'($urandom);
      npe = 1'($urandom_range(0, 1));
      npt = 1'($urandom_range(0, 1));
      check_frame(d, pe, pt, noise, chain_n, nd, npe, npt);
      d  = nd;
      pe = npe;
      pt = npt;
      chained = chain_n;
    end

    repeat (2) @(negedge CLK);
    check_idle("final");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
